// File: rtl/db_pulse_tx_if.sv
// Request/status bundle for db_pulse_tx: the master issues strobes and overflow clears,
// the slave (db_pulse_tx) returns the conditioned line and queue status.
interface db_pulse_tx_if #(
  parameter int PEND_DEPTH = 7
) ();
  localparam int PW = $clog2(PEND_DEPTH + 1);

  logic          i_req;
  logic          i_clr_ovf;
  logic          o_signal;
  logic          o_busy;
  logic [PW-1:0] o_pending;
  logic          o_ovf;

  modport master (
    output i_req, i_clr_ovf,
    input  o_signal, o_busy, o_pending, o_ovf
  );

  modport slave (
    input  i_req, i_clr_ovf,
    output o_signal, o_busy, o_pending, o_ovf
  );
endinterface

// File: rtl/db_pulse_tx.sv
// Turns single-cycle request strobes into clean pulses: HIGH_CYCLE clocks high, then at least
// LOW_CYCLE clocks low; requests arriving mid-pulse are queued (up to PEND_DEPTH) and replayed.
module db_pulse_tx #(
  parameter int HIGH_CYCLE = 32,
  parameter int LOW_CYCLE  = 32,
  parameter int PEND_DEPTH = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  db_pulse_tx_if.slave bus
);
  localparam int PW   = $clog2(PEND_DEPTH + 1);
  localparam int MAXC = (HIGH_CYCLE > LOW_CYCLE) ? HIGH_CYCLE : LOW_CYCLE;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLE - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLE - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_DEPTH);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pending;
  logic [PW-1:0] pend_nxt;
  logic          sig;
  logic          ovf;

  logic low_end;
  logic start;
  logic dec;
  logic inc;
  logic drop;

  // A new pulse may only begin from IDLE or on the final edge of the guard time.
  assign low_end = (state == LOW) && (cnt == '0);
  assign start   = ((state == IDLE) || low_end) && (bus.i_req || (pending != '0));
  assign dec     = start && (pending != '0);
  assign inc     = bus.i_req && !(start && (pending == '0));
  assign drop    = inc && !dec && (pending == PEND_FULL);

  always_comb begin
    pend_nxt = pending;
    if (inc && !dec && (pending != PEND_FULL)) begin
      pend_nxt = pending + PW'(1);
    end else if (dec && !inc) begin
      pend_nxt = pending - PW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sig     <= 1'b0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (drop) begin
        ovf <= 1'b1;
      end else if (bus.i_clr_ovf) begin
        ovf <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= HIGH;
            sig   <= 1'b1;
            cnt   <= HIGH_LOAD;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            state <= LOW;
            sig   <= 1'b0;
            cnt   <= LOW_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        LOW: begin
          if (cnt == '0) begin
            if (start) begin
              state <= HIGH;
              sig   <= 1'b1;
              cnt   <= HIGH_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          sig   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_signal  = sig;
  assign bus.o_pending = pending;
  assign bus.o_ovf     = ovf;
  assign bus.o_busy    = (state != IDLE) || (pending != '0);
endmodule

// File: tb/tb_db_pulse_tx.sv
// Bench for db_pulse_tx: directed scenarios plus random requests against a timeline model
// that tracks pulse start times and a pending count.
module tb_db_pulse_tx;
  localparam int H = 4;
  localparam int L = 3;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  db_pulse_tx_if #(.PEND_DEPTH(D)) bus ();

  db_pulse_tx #(
    .HIGH_CYCLE(H),
    .LOW_CYCLE (L),
    .PEND_DEPTH(D)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: time of the most recent pulse start and the number of queued requests.
  int   t = 0;
  int   last = 0;
  bit   have = 1'b0;
  int   pend = 0;
  bit   mdl_ovf = 1'b0;
  logic [4:0] exp_v;
  logic [4:0] obs_v;

  assign obs_v = {bus.o_signal, bus.o_busy, bus.o_pending, bus.o_ovf};

  task automatic model_reset();
    have    = 1'b0;
    pend    = 0;
    mdl_ovf = 1'b0;
    exp_v   = '0;
  endtask

  // Drives one clock of stimulus, advances the model, and leaves time just past the edge.
  task automatic step(input bit req, input bit clr);
    bit free;
    bit drop;
    bit e_sig;
    bit e_busy;
    bus.i_req     = req;
    bus.i_clr_ovf = clr;
    @(posedge clk);
    t++;
    free = !have || ((t - last) >= (H + L));
    drop = 1'b0;
    if (free && (req || pend > 0)) begin
      last = t;
      have = 1'b1;
      if (pend > 0 && !req) pend--;
    end else if (req) begin
      if (pend < D) pend++;
      else drop = 1'b1;
    end
    if (drop) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    e_sig  = have && ((t - last) < H);
    e_busy = (have && ((t - last) < (H + L))) || (pend > 0);
    exp_v  = {e_sig, e_busy, 2'(pend), mdl_ovf};
    #1;
  endtask

  task automatic test_reset();
    if (obs_v !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs_v, 5'b0);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_single();
    int highs = 0;
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b0);
      if (bus.o_signal) highs++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL single t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
    end
    if (highs !== H) begin
      errors++;
      $display("FAIL single_width got=%0d exp=%0d", highs, H);
    end
    checks++;
  endtask

  task automatic test_burst();
    for (int i = 0; i < 26; i++) begin
      step(i < 3, 1'b0);
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL burst t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 26; i++) begin
      step(i < 4, i == 10);
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL overflow t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
      if (i == 3 && (bus.o_ovf !== 1'b1 || bus.o_pending !== 2'(D))) begin
        errors++;
        $display("FAIL overflow_drop ovf=%b pend=%0d exp ovf=1 pend=%0d", bus.o_ovf, bus.o_pending, D);
      end
      if (i == 3) checks++;
    end
  endtask

  task automatic test_low_end();
    int max_pend = 0;
    int rise_gap = -1;
    for (int i = 0; i < 16; i++) begin
      step(i == 0 || i == (H + L), 1'b0);
      if (int'(bus.o_pending) > max_pend) max_pend = int'(bus.o_pending);
      if (i == (H + L) && bus.o_signal === 1'b1) rise_gap = i;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL low_end t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
    end
    if (max_pend !== 0 || rise_gap !== (H + L)) begin
      errors++;
      $display("FAIL low_end_direct max_pend=%0d rise=%0d exp 0 and %0d", max_pend, rise_gap, H + L);
    end
    checks++;
  endtask

  task automatic test_collision();
    for (int i = 0; i < 30; i++) begin
      step(i < 5, i == 4 || i == 12);
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL collision t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
      if (i == 4 && bus.o_ovf !== 1'b1) begin
        errors++;
        $display("FAIL collision_set_wins ovf=%b exp=1", bus.o_ovf);
      end
      if (i == 4) checks++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(i < 3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    if (obs_v !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs_v, 5'b0);
    end
    checks++;
    @(posedge clk);
    t++;
    #1;
    if (obs_v !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_hold got=%b exp=%b", obs_v, 5'b0);
    end
    checks++;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(i == 10, 1'b0);
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_after t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    bit r;
    bit c;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 30);
      c = ($urandom_range(0, 99) < 8);
      step(r, c);
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random t=%0d req=%b clr=%b got=%b exp=%b", t, r, c, obs_v, exp_v);
      end
      checks++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    bus.i_req     = 1'b0;
    bus.i_clr_ovf = 1'b0;
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    test_single();
    drain();
    test_burst();
    drain();
    test_overflow();
    drain();
    test_low_end();
    drain();
    test_collision();
    drain();
    test_reset_mid();
    drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/db_pulse_tx.md
# db_pulse_tx

Transmit-side conditioner that drives a debounced, synchronised output line. Internal logic issues single-cycle request strobes. The block converts each strobe into one clean pulse on `o_signal`: high for exactly `HIGH_CYCLE` clocks, then low for at least `LOW_CYCLE` clocks. A far-end `DB_CYCLE`-style debouncer therefore sees every pulse as one stable high level and one stable low level. Requests that arrive while a pulse is in flight are counted and replayed back-to-back.

## Interface
- `HIGH_CYCLE`, 32, high time of each pulse in clocks (≥1; must exceed the far-end debounce count).
- `LOW_CYCLE`, 32, minimum low/guard time after each pulse in clocks (≥1).
- `PEND_DEPTH`, 7, maximum number of queued requests (≥1).
- `i_clk`  input  1  system clock; all state changes on the rising edge.
- `i_rst`  input  1  reset, asynchronous, active-high.
- `i_req`  input  1  request strobe; every cycle sampled high is one request.
- `i_clr_ovf`  input  1  synchronous clear of `o_ovf`.
- `o_signal`  output  1  conditioned output line, registered.
- `o_busy`  output  1  high when state ≠ IDLE or pending ≠ 0.
- `o_pending`  output  $clog2(PEND_DEPTH+1)  number of queued requests not yet started.
- `o_ovf`  output  1  sticky flag; set when a request is dropped.

## Operation
- FSM states: IDLE, HIGH, LOW. Phase counter width is $clog2(max(HIGH_CYCLE,LOW_CYCLE)+1).
- **IDLE:** `o_signal`=0.
  - If `i_req`=1 or pending>0 at an edge: go to HIGH, set `o_signal`=1, load phase counter.
  - Consume one request: the live `i_req` if pending=0, otherwise decrement pending. If pending>0 and `i_req`=1 together, pending is unchanged (−1 +1).
- **HIGH:** `o_signal`=1 for exactly `HIGH_CYCLE` cycles, then go to LOW with `o_signal`=0.
- **LOW:** `o_signal`=0 for exactly `LOW_CYCLE` cycles. At the end:
  - if pending>0 (counted after this edge's `i_req`): go to HIGH and decrement pending;
  - else if `i_req`=1 at that edge: go to HIGH and consume it directly;
  - else go to IDLE.
- **Pending update:** `i_req` in HIGH or LOW (not consumed directly) increments pending. Increment and decrement in the same cycle net to zero.
- **Overflow:**
  - `i_req` while pending=`PEND_DEPTH` with no decrement that cycle: request dropped, pending holds, `o_ovf`←1.
  - `i_clr_ovf`=1 clears `o_ovf`. If a drop occurs in the same cycle, set wins.
- `o_busy` is decoded from registered state and pending only; no combinational path from any input.
- **Reset (asynchronous, any time, including mid-pulse):** state=IDLE, `o_signal`=0, pending=0, counters=0, `o_ovf`=0, `o_busy`=0. A truncated high pulse is accepted behaviour. No request survives reset.

## Timing
- Start latency: `i_req` sampled at edge k while IDLE gives `o_signal`=1 from edge k to edge k+`HIGH_CYCLE`, then 0.
- Back-to-back period: `HIGH_CYCLE`+`LOW_CYCLE` clocks. No gap beyond `LOW_CYCLE` when requests are queued.
- Low time between pulses is never shorter than `LOW_CYCLE`. High time is never other than `HIGH_CYCLE`, except when truncated by reset.
- `o_pending`, `o_ovf` and `o_busy` update at the same edge as the event that changes them.
- Reset values of all outputs are 0.

## Test plan
Bench parameters: `HIGH_CYCLE`=4, `LOW_CYCLE`=3, `PEND_DEPTH`=2.
- **Single request:** one-cycle `i_req` at edge 10 → `o_signal` high on edges 10–13, low from edge 14; `o_busy` high over 10–16, low from edge 17; `o_pending` stays 0.
- **Burst of three:** `i_req` at edges 10, 11, 12 → `o_pending` reads 1 then 2; three pulses rising at edges 10, 17, 24; `o_busy` drops at edge 31; `o_ovf`=0.
- **Overflow:** `i_req` held high over edges 10–13 → two requests queued, one dropped at edge 13; `o_ovf`=1, `o_pending`=2. `i_clr_ovf` at edge 20 → `o_ovf`=0.
- **Request at LOW end:** `i_req` at edge 10, second `i_req` at edge 17 (the final LOW edge) → second pulse rises at edge 17 with no extra gap; `o_pending` never exceeds 0.
- **Clear/set collision:** with `o_ovf`=1, assert `i_clr_ovf` in the same cycle as a dropped request → `o_ovf` remains 1.
- **Reset mid-pulse:** assert `i_rst` asynchronously mid-HIGH with pending=2 → `o_signal`, `o_pending`, `o_busy` and `o_ovf` go to 0 immediately. After release, no pulse is emitted until a new `i_req`.
